adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin arbiter that shares a single `adder` datapath between `NUM_REQ` independent requesters. Each requester presents operand pairs on a valid/ready channel. The block grants one requester at a time, sequences the operation through a registered adder stage, and returns the sum on a single response channel tagged with the requester ID. It sits between the requesting units and the shared `adder` instance and owns all sequencing of that adder.

## Interface
Parameters:
- `DATA_WIDTH`, default 16, operand and result width.
- `NUM_REQ`, default 4, number of requesters; legal range 2..16.
- `ID_WIDTH`, default `$clog2(NUM_REQ)`, width of the requester tag.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst`, input, 1, reset, synchronous and active-high.
- `req_valid`, input, `NUM_REQ`, one request-valid bit per requester.
- `req_ready`, output, `NUM_REQ`, per-requester accept; at most one bit set (one-hot or zero).
- `req_a`, input, `NUM_REQ*DATA_WIDTH`, flattened operand A; requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_b`, input, `NUM_REQ*DATA_WIDTH`, flattened operand B, same packing as `req_a`.
- `rsp_valid`, output, 1, result available.
- `rsp_ready`, input, 1, response consumer accepts.
- `rsp_id`, output, `ID_WIDTH`, index of the requester that owns `rsp_data`.
- `rsp_data`, output, `DATA_WIDTH`, sum `(A + B) mod 2^DATA_WIDTH`.
- `busy`, output, 1, high in any state other than IDLE.
- `rsp_ovf`, output, 1, present only with `ADDER_ARB_OVF_EN`; carry-out of the sum.

## Operation
State machine: IDLE -> CALC -> RESP -> IDLE.

- **IDLE**
  - The grant is the first requester i with `req_valid[i]` set, scanning from `ptr` upward and wrapping from `NUM_REQ-1` to 0.
  - `req_ready[grant]` is 1; all other bits are 0.
  - If any `req_valid` is set, the handshake completes: latch `op_a`, `op_b`, and `id = grant`, then go to CALC.
  - If no `req_valid` is set, stay in IDLE; `ptr` is unchanged.
- **CALC**
  - The `adder` instance is driven from `op_a`/`op_b`.
  - Its output is registered into `res` (and the carry-out when `ADDER_ARB_OVF_EN` is defined).
  - Go to RESP unconditionally.
- **RESP**
  - `rsp_valid` = 1; `rsp_id`, `rsp_data`, and `rsp_ovf` are stable.
  - When `rsp_ready` is 1: go to IDLE and set `ptr = (id + 1) mod NUM_REQ`.
  - When `rsp_ready` is 0: hold indefinitely; no new request is accepted.
- `req_ready` is all-zero in CALC and RESP.
- **Protocol rule:** a requester keeps `req_valid` and its operands stable until it sees `req_ready`. Dropping `req_valid` before the grant is legal, and that requester is simply skipped.
- **Arithmetic:** the sum wraps modulo `2^DATA_WIDTH`. Example: `0xFFFF + 0x0002` gives `0x0001`.
- **Fairness:** every requester holding `req_valid` is served within `NUM_REQ` transactions.

## Timing
- Reset values: state = IDLE, `ptr` = 0, `req_ready` = 0 while `rst` is high, `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `busy` = 0, `rsp_ovf` = 0.
- Request accepted in cycle N, so `rsp_valid` rises in cycle N+2.
- If `rsp_ready` is already high in cycle N+2, the earliest next accept is cycle N+3. Peak throughput is one operation per 3 cycles.
- `req_ready` is a combinational function of the registered state, `ptr`, and `req_valid`.
- All outputs other than `req_ready` are registered.
- Reset asserted mid-operation, in CALC or RESP: the in-flight operation is discarded and no response is issued. The cycle after reset deasserts, the block is in IDLE with `ptr` = 0.
- When a new request and a response completion fall in the same cycle, the response completes first. The new request is evaluated in the next cycle (IDLE), using the updated `ptr`.

## Configuration
- Macro: `ADDER_ARB_OVF_EN`.
- Defined: the `rsp_ovf` port exists and carries the carry-out bit `A + B >= 2^DATA_WIDTH` for the transaction on `rsp_data`. The adder stage is computed internally at `DATA_WIDTH+1` bits.
- Undefined: no `rsp_ovf` port and no carry register; the sum is plain `DATA_WIDTH` wide.

## Structure
- Shared package holds:
  - the state encoding constants `ST_IDLE = 2'd0`, `ST_CALC = 2'd1`, `ST_RESP = 2'd2`;
  - the `NUM_REQ` legal-range limits.
- One sub-module: `rr_pick`. It is a purely combinational round-robin selector with inputs `req_valid` and `ptr`, and outputs `grant` index and `any`.
- The existing `adder` module is instantiated once for the datapath.

## Test plan
- Single request: `req_valid = 4'b0001`, A=3, B=4. Expect `req_ready[0]` in the same cycle; two cycles later `rsp_valid` with `rsp_id`=0 and `rsp_data`=7.
- Wrap-around: requester 2 sends `0xFFFF + 0x0002`. Expect `rsp_data`=`0x0001` and `rsp_id`=2; with the macro defined, also expect `rsp_ovf`=1.
- All four requesters valid continuously from reset. Expect grants in order 0, 1, 2, 3, 0, with one response every 3 cycles and `rsp_id` matching.
- Backpressure: `rsp_ready` held 0 for 5 cycles in RESP. Expect `rsp_valid`, `rsp_id`, and `rsp_data` stable, and `req_ready` all-zero throughout; release gives IDLE the next cycle.
- Reset in CALC with requester 1 in flight. Expect no response, `ptr`=0, and `busy`=0; afterwards requester 1 (still valid) is regranted and its correct sum is returned.
- `ptr`=3 with only requester 1 valid. Expect grant 1 with no idle gap; `ptr` becomes 2 after the response.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder_arbiter slice: FSM state encoding and
// the supported requester-count range.
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 16;

endpackage

// File: rtl/adder.sv
// Shared combinational adder datapath; the arbiter owns its sequencing
// and registers the result.
module adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/adder_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first valid
// requester at or after ptr, wrapping at NUM_REQ-1.
module rr_pick
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] grant,
  output logic                any
);

  logic [2*NUM_REQ-1:0] rotated;

  // Doubling the vector lets a plain right shift implement the wrap.
  assign rotated = {req_valid, req_valid} >> ptr;

  // Scan from the farthest offset down so the nearest hit is the final write.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (rotated[off]) begin
        grant = ID_WIDTH'((int'(ptr) + off) % NUM_REQ);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one adder among NUM_REQ requesters.
// Define ADDER_ARB_OVF_EN to add the rsp_ovf carry-out port.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic                          rsp_ovf
`endif
);

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
    $error("adder_arbiter: NUM_REQ out of range");
  end

`ifdef ADDER_ARB_OVF_EN
  localparam int SUM_WIDTH = DATA_WIDTH + 1;
`else
  localparam int SUM_WIDTH = DATA_WIDTH;
`endif

  state_t                state_q;
  state_t                state_d;
  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ID_WIDTH-1:0]   grant;
  logic [ID_WIDTH-1:0]   ptr_next;
  logic                  any;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] res;
  logic [SUM_WIDTH-1:0]  add_a;
  logic [SUM_WIDTH-1:0]  add_b;
  logic [SUM_WIDTH-1:0]  add_sum;
  logic [DATA_WIDTH-1:0] lane_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] lane_b [NUM_REQ];
`ifdef ADDER_ARB_OVF_EN
  logic                  ovf;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_a[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
    assign lane_b[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .any       (any)
  );

  // Operands are zero-extended so the top sum bit is the carry-out when enabled.
  assign add_a = SUM_WIDTH'(op_a);
  assign add_b = SUM_WIDTH'(op_b);

  adder #(
    .WIDTH (SUM_WIDTH)
  ) u_adder (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  assign ptr_next = (id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id_q + ID_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any) state_d = ST_CALC;
      ST_CALC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == ST_IDLE && any) req_ready[grant] = 1'b1;
  end

  // Datapath and registered outputs; rsp_valid/busy track the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      id_q      <= '0;
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      rsp_valid <= (state_d == ST_RESP);
      busy      <= (state_d != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (any) begin
            op_a <= lane_a[grant];
            op_b <= lane_b[grant];
            id_q <= grant;
          end
        end
        ST_CALC: begin
          res <= add_sum[DATA_WIDTH-1:0];
`ifdef ADDER_ARB_OVF_EN
          ovf <= add_sum[DATA_WIDTH];
`endif
        end
        ST_RESP: begin
          if (rsp_ready) ptr <= ptr_next;
        end
        default: ;
      endcase
    end
  end

  assign rsp_id   = id_q;
  assign rsp_data = res;
`ifdef ADDER_ARB_OVF_EN
  assign rsp_ovf  = ovf;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter: a vector table of single
// transactions plus hand-written multi-cycle sequences.
module tb_adder_arbiter;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   reqValid;
  logic [NR-1:0]   reqReady;
  logic [NR*DW-1:0] reqA;
  logic [NR*DW-1:0] reqB;
  logic            rspValid;
  logic            rspReady;
  logic [IW-1:0]   rspId;
  logic [DW-1:0]   rspData;
  logic            busy;
`ifdef ADDER_ARB_OVF_EN
  logic            rspOvf;
`endif

  typedef struct {
    logic [3:0]  valid;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  expReady;
    logic [1:0]  expId;
    logic [15:0] expData;
    logic        expOvf;
  } vec_t;

  vec_t vecs [9];
  int testsRun = 0;
  int testsFailed = 0;

  adder_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .ID_WIDTH   (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_a     (reqA),
    .req_b     (reqB),
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_id    (rspId),
    .rsp_data  (rspData),
    .busy      (busy)
`ifdef ADDER_ARB_OVF_EN
    ,
    .rsp_ovf   (rspOvf)
`endif
  );

  always #5 clk = ~clk;

  // Hard stop in case a sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [63:0] a, input logic [63:0] b, input logic rr);
    reqValid = v;
    reqA     = a;
    reqB     = b;
    rspReady = rr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4'b0000, 64'h0, 64'h0, 1'b0);
    nextCycle();
    rst = 1'b0;
  endtask

  // One full transaction from IDLE: grant, CALC, RESP, back to IDLE.
  task automatic runVector(input int i);
    applyStimulus(vecs[i].valid, vecs[i].a, vecs[i].b, 1'b0);
    #1;
    checkOutput($sformatf("v%0d_ready", i), 64'(reqReady), 64'(vecs[i].expReady));
    nextCycle();
    applyStimulus(4'b0000, vecs[i].a, vecs[i].b, 1'b0);
    checkOutput($sformatf("v%0d_calc_busy", i), 64'(busy), 64'd1);
    checkOutput($sformatf("v%0d_calc_valid", i), 64'(rspValid), 64'd0);
    checkOutput($sformatf("v%0d_calc_ready", i), 64'(reqReady), 64'd0);
    nextCycle();
    checkOutput($sformatf("v%0d_rsp_valid", i), 64'(rspValid), 64'd1);
    checkOutput($sformatf("v%0d_rsp_id", i), 64'(rspId), 64'(vecs[i].expId));
    checkOutput($sformatf("v%0d_rsp_data", i), 64'(rspData), 64'(vecs[i].expData));
`ifdef ADDER_ARB_OVF_EN
    checkOutput($sformatf("v%0d_rsp_ovf", i), 64'(rspOvf), 64'(vecs[i].expOvf));
`endif
    rspReady = 1'b1;
    nextCycle();
    checkOutput($sformatf("v%0d_idle_valid", i), 64'(rspValid), 64'd0);
    checkOutput($sformatf("v%0d_idle_busy", i), 64'(busy), 64'd0);
    rspReady = 1'b0;
  endtask

  initial begin
    int rspSeen;
    logic [15:0] contData [4];
    logic [63:0] allA;
    logic [63:0] allB;

    allA = {16'hAAAA, 16'h7FFF, 16'h0010, 16'h0001};
    allB = {16'h5555, 16'h0001, 16'h0020, 16'h0001};

    // Expected values are hand-computed, walking ptr from 0 after reset.
    vecs[0] = '{4'b0001, {16'h0, 16'h0, 16'h0, 16'h0003}, {16'h0, 16'h0, 16'h0, 16'h0004},
                4'b0001, 2'd0, 16'h0007, 1'b0};
    vecs[1] = '{4'b0100, {16'h0, 16'hFFFF, 16'h0, 16'h0}, {16'h0, 16'h0002, 16'h0, 16'h0},
                4'b0100, 2'd2, 16'h0001, 1'b1};
    vecs[2] = '{4'b0010, {16'h0, 16'h0, 16'h1234, 16'h0}, {16'h0, 16'h0, 16'h1111, 16'h0},
                4'b0010, 2'd1, 16'h2345, 1'b0};
    vecs[3] = '{4'b0110, {16'h0, 16'h00FF, 16'h0001, 16'h0}, {16'h0, 16'h0001, 16'h0001, 16'h0},
                4'b0100, 2'd2, 16'h0100, 1'b0};
    vecs[4] = '{4'b1001, {16'h0010, 16'h0, 16'h0, 16'h8000}, {16'h0020, 16'h0, 16'h0, 16'h8000},
                4'b1000, 2'd3, 16'h0030, 1'b0};
    vecs[5] = '{4'b1001, {16'h0010, 16'h0, 16'h0, 16'h8000}, {16'h0020, 16'h0, 16'h0, 16'h8000},
                4'b0001, 2'd0, 16'h0000, 1'b1};
    vecs[6] = '{4'b1111, allA, allB, 4'b0010, 2'd1, 16'h0030, 1'b0};
    vecs[7] = '{4'b1111, allA, allB, 4'b0100, 2'd2, 16'h8000, 1'b0};
    vecs[8] = '{4'b1111, allA, allB, 4'b1000, 2'd3, 16'hFFFF, 1'b0};

    // Reset state, with every requester asserting valid during reset.
    rst = 1'b1;
    applyStimulus(4'b1111, allA, allB, 1'b1);
    nextCycle();
    nextCycle();
    checkOutput("reset_req_ready", 64'(reqReady), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rspValid), 64'd0);
    checkOutput("reset_rsp_id", 64'(rspId), 64'd0);
    checkOutput("reset_rsp_data", 64'(rspData), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
`ifdef ADDER_ARB_OVF_EN
    checkOutput("reset_rsp_ovf", 64'(rspOvf), 64'd0);
`endif
    applyStimulus(4'b0000, 64'h0, 64'h0, 1'b0);
    rst = 1'b0;
    nextCycle();

    for (int i = 0; i < 9; i++) runVector(i);

    // All requesters valid from reset, consumer always ready: one response per 3 cycles.
    contData[0] = 16'h0002;
    contData[1] = 16'h0030;
    contData[2] = 16'h8000;
    contData[3] = 16'hFFFF;
    rst = 1'b1;
    applyStimulus(4'b1111, allA, allB, 1'b1);
    nextCycle();
    rst = 1'b0;
    rspSeen = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (rspValid) begin
        if (rspSeen < 5) begin
          checkOutput($sformatf("cont%0d_cycle", rspSeen), 64'(cyc), 64'(2 + 3 * rspSeen));
          checkOutput($sformatf("cont%0d_id", rspSeen), 64'(rspId), 64'(rspSeen % 4));
          checkOutput($sformatf("cont%0d_data", rspSeen), 64'(rspData), 64'(contData[rspSeen % 4]));
        end
        rspSeen++;
      end
      nextCycle();
    end
    checkOutput("cont_count", 64'(rspSeen), 64'd6);

    // Backpressure: requester 1 held in RESP while everyone else waits.
    doReset();
    applyStimulus(4'b0010, {16'h0, 16'h0, 16'h0005, 16'h0}, {16'h0, 16'h0, 16'h0006, 16'h0}, 1'b0);
    #1;
    checkOutput("bp_grant", 64'(reqReady), 64'b0010);
    nextCycle();
    applyStimulus(4'b1111, {16'h0, 16'h0, 16'h0005, 16'h0}, {16'h0, 16'h0, 16'h0006, 16'h0}, 1'b0);
    checkOutput("bp_calc_ready", 64'(reqReady), 64'd0);
    nextCycle();
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp%0d_valid", k), 64'(rspValid), 64'd1);
      checkOutput($sformatf("bp%0d_id", k), 64'(rspId), 64'd1);
      checkOutput($sformatf("bp%0d_data", k), 64'(rspData), 64'h000B);
      checkOutput($sformatf("bp%0d_ready", k), 64'(reqReady), 64'd0);
      nextCycle();
    end
    checkOutput("bp_last_valid", 64'(rspValid), 64'd1);
    rspReady = 1'b1;
    nextCycle();
    checkOutput("bp_release_valid", 64'(rspValid), 64'd0);
    checkOutput("bp_release_busy", 64'(busy), 64'd0);
    checkOutput("bp_release_grant", 64'(reqReady), 64'b0100);
    applyStimulus(4'b0000, 64'h0, 64'h0, 1'b0);

    // Reset during CALC: ptr is 2 here, so a stale ptr would favour requester 3.
    applyStimulus(4'b0010, {16'h0, 16'h0, 16'h0100, 16'h0}, {16'h0, 16'h0, 16'h0023, 16'h0}, 1'b0);
    #1;
    checkOutput("rc_grant", 64'(reqReady), 64'b0010);
    nextCycle();
    checkOutput("rc_calc_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    applyStimulus(4'b1010, {16'h0001, 16'h0, 16'h0100, 16'h0}, {16'h0001, 16'h0, 16'h0023, 16'h0}, 1'b0);
    nextCycle();
    checkOutput("rc_rst_valid", 64'(rspValid), 64'd0);
    checkOutput("rc_rst_busy", 64'(busy), 64'd0);
    checkOutput("rc_rst_ready", 64'(reqReady), 64'd0);
    checkOutput("rc_rst_data", 64'(rspData), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("rc_regrant", 64'(reqReady), 64'b0010);
    nextCycle();
    applyStimulus(4'b0000, 64'h0, 64'h0, 1'b0);
    checkOutput("rc_calc_valid", 64'(rspValid), 64'd0);
    nextCycle();
    checkOutput("rc_rsp_valid", 64'(rspValid), 64'd1);
    checkOutput("rc_rsp_id", 64'(rspId), 64'd1);
    checkOutput("rc_rsp_data", 64'(rspData), 64'h0123);
    rspReady = 1'b1;
    nextCycle();
    checkOutput("rc_done_valid", 64'(rspValid), 64'd0);
    rspReady = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
